// File: rtl/qlf_k6n10_scan_pkg.sv
// Shared types and sizing for the scff chain loader and its serializer.
package qlf_k6n10_scan_pkg;

  localparam int WORD_W_DEF = 32;
  localparam int CNT_W      = $clog2(4096) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Bits to take from a freshly accepted word: a short final word only uses its top bits.
  function automatic logic [CNT_W-1:0] min_bits(input logic [CNT_W-1:0] remain, input int word_w);
    if (remain < CNT_W'(word_w)) return remain;
    return CNT_W'(word_w);
  endfunction

endpackage

// File: rtl/scan_shift_word.sv
// Serializer (MSB first onto scan_d) and readback capture of the chain tail.
module scan_shift_word
  import qlf_k6n10_scan_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] word_in,
  input  logic              shift,
  input  logic              last,
  input  logic              scan_q,
  output logic              scan_d,
  output logic [WORD_W-1:0] rb_word,
  output logic              rb_valid
);
  localparam int CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] sreg;
  logic [WORD_W-1:0] cap;
  logic [CW-1:0]     cap_cnt;
  logic              word_full;

  // Gated so the chain head sees 0 whenever it is not shifting.
  assign scan_d    = shift & sreg[WORD_W-1];
  assign word_full = (cap_cnt == CW'(WORD_W - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg     <= '0;
      cap      <= '0;
      cap_cnt  <= '0;
      rb_word  <= '0;
      rb_valid <= 1'b0;
    end else begin
      rb_valid <= 1'b0;
      if (load) sreg <= word_in;
      else if (shift) sreg <= sreg << 1;
      if (shift) begin
        if (word_full || last) begin
          rb_word  <= {cap[WORD_W-2:0], scan_q};
          rb_valid <= 1'b1;
          cap      <= '0;
          cap_cnt  <= '0;
        end else begin
          cap     <= {cap[WORD_W-2:0], scan_q};
          cap_cnt <= cap_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/scff_chain_loader.sv
// Loads a CHAIN_LEN-bit scff scan chain from a stream of words and captures readback.
//   state    | meaning
//   ST_IDLE  | waiting for start
//   ST_WAIT  | no word held, chain paused, word_ready high
//   ST_SHIFT | word held, one chain shift per cycle
//   ST_DONE  | single-cycle done pulse, then IDLE
module scff_chain_loader
  import qlf_k6n10_scan_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              scan_en,
  output logic              scan_d,
  input  logic              scan_q,
  output logic [WORD_W-1:0] rb_word,
  output logic              rb_valid,
  output logic              busy,
  output logic              done
);
  state_t           state, state_nx;
  logic [CNT_W-1:0] total_cnt;
  logic [CNT_W-1:0] bits_left;
  logic [CNT_W-1:0] remain;
  logic             load;
  logic             last;

  assign busy   = (state != ST_IDLE);
  assign last   = scan_en && (total_cnt == CNT_W'(1));
  assign remain = scan_en ? (total_cnt - CNT_W'(1)) : total_cnt;

  always_comb begin
    state_nx   = state;
    word_ready = 1'b0;
    scan_en    = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    unique case (state)
      ST_IDLE: if (start) state_nx = ST_WAIT;
      ST_WAIT: begin
        word_ready = 1'b1;
        if (word_valid) begin
          load     = 1'b1;
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        scan_en = 1'b1;
        if (total_cnt == CNT_W'(1)) begin
          state_nx = ST_DONE;
        end else if (bits_left == CNT_W'(1)) begin
          // Accept the next word while the last bit leaves, so there is no bubble.
          word_ready = 1'b1;
          if (word_valid) load = 1'b1;
          else state_nx = ST_WAIT;
        end
      end
      ST_DONE: begin
        done     = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      total_cnt <= '0;
      bits_left <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && start) total_cnt <= CNT_W'(CHAIN_LEN);
      else if (scan_en) total_cnt <= total_cnt - CNT_W'(1);
      if (load) bits_left <= min_bits(remain, WORD_W);
      else if (scan_en) bits_left <= bits_left - CNT_W'(1);
    end
  end

  scan_shift_word #(.WORD_W(WORD_W)) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .word_in  (word_in),
    .shift    (scan_en),
    .last     (last),
    .scan_q   (scan_q),
    .scan_d   (scan_d),
    .rb_word  (rb_word),
    .rb_valid (rb_valid)
  );

endmodule

// File: tb/tb_scff_chain_loader.sv
// Directed bench: 64-cell and 40-cell loopback chains driven by two loader instances.
module tb_scff_chain_loader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start64, start40;
  logic [31:0] word_in;
  logic        word_valid;

  logic        ready64, en64, d64, q64, rbv64, busy64, done64;
  logic [31:0] rb64;
  logic        ready40, en40, d40, q40, rbv40, busy40, done40;
  logic [31:0] rb40;

  logic [63:0] chain64 = '0;
  logic [39:0] chain40 = '0;

  bit use40 = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (en64) chain64 <= {chain64[62:0], d64};
  always @(posedge clk) if (en40) chain40 <= {chain40[38:0], d40};
  assign q64 = chain64[63];
  assign q40 = chain40[39];

  wire        o_ready = use40 ? ready40 : ready64;
  wire        o_en    = use40 ? en40 : en64;
  wire        o_d     = use40 ? d40 : d64;
  wire        o_rbv   = use40 ? rbv40 : rbv64;
  wire        o_done  = use40 ? done40 : done64;
  wire [31:0] o_rb    = use40 ? rb40 : rb64;

  scff_chain_loader #(.CHAIN_LEN(64), .WORD_W(32)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .start(start64), .word_in(word_in), .word_valid(word_valid),
    .word_ready(ready64), .scan_en(en64), .scan_d(d64), .scan_q(q64),
    .rb_word(rb64), .rb_valid(rbv64), .busy(busy64), .done(done64));

  scff_chain_loader #(.CHAIN_LEN(40), .WORD_W(32)) u_dut40 (
    .clk(clk), .rst_n(rst_n), .start(start40), .word_in(word_in), .word_valid(word_valid),
    .word_ready(ready40), .scan_en(en40), .scan_d(d40), .scan_q(q40),
    .rb_word(rb40), .rb_valid(rbv40), .busy(busy40), .done(done40));

  // Drives one full load (cycle 0 = start cycle) and records what the selected DUT did.
  task automatic run_load(input logic [31:0] w0, input logic [31:0] w1, input int gap,
                          input int busy_start_at, output int n_shift, output int done_at,
                          output int first_en, output logic [63:0] stream, output int n_rb,
                          output logic [31:0] rb0, output logic [31:0] rb1, output int rb1_at,
                          output int stalls, output logic ready_at_done);
    int widx, gap_cnt;
    bit xfer;
    n_shift = 0; done_at = -1; first_en = -1; stream = '0; n_rb = 0;
    rb0 = '0; rb1 = '0; rb1_at = -1; stalls = 0; ready_at_done = 1'b1;
    widx = 0; gap_cnt = 0; xfer = 1'b0;
    @(negedge clk);
    if (use40) start40 = 1'b1; else start64 = 1'b1;
    for (int cyc = 0; cyc < 300; cyc++) begin
      if (cyc > 0) begin
        @(negedge clk);
        start64 = 1'b0;
        start40 = 1'b0;
      end
      if (cyc == busy_start_at) begin
        if (use40) start40 = 1'b1; else start64 = 1'b1;
      end
      if (xfer) widx++;
      if (o_en) begin
        if (first_en < 0) first_en = cyc;
        n_shift++;
        stream = {stream[62:0], o_d};
      end else if (n_shift > 0 && !o_done) begin
        stalls++;
      end
      if (o_rbv) begin
        if (n_rb == 0) rb0 = o_rb;
        else begin rb1 = o_rb; rb1_at = cyc; end
        n_rb++;
      end
      if (o_done) begin
        done_at = cyc;
        ready_at_done = o_ready;
        break;
      end
      if (widx == 0) begin
        word_in = w0; word_valid = 1'b1;
      end else if (widx == 1) begin
        word_in = w1;
        if (o_ready && gap_cnt < gap) begin word_valid = 1'b0; gap_cnt++; end
        else word_valid = 1'b1;
      end else begin
        word_valid = 1'b0;
      end
      xfer = word_valid && o_ready;
    end
    word_valid = 1'b0;
    start64 = 1'b0;
    start40 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start64 = 1'b0; start40 = 1'b0; word_in = '0; word_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({ready64, en64, d64, rbv64, done64, busy64} !== 6'b0) begin errors++;
      $display("FAIL reset_ctrl64 got %b want 000000", {ready64, en64, d64, rbv64, done64, busy64}); end
    checks++; if (rb64 !== 32'h0) begin errors++; $display("FAIL reset_rb64 got %h want 0", rb64); end
    checks++; if ({ready40, en40, busy40, done40, rbv40} !== 5'b0 || rb40 !== 32'h0) begin errors++;
      $display("FAIL reset_40 got %b/%h want 0", {ready40, en40, busy40, done40, rbv40}, rb40); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle_words();
    word_in = 32'hDEADBEEF; word_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (ready64 !== 1'b0 || busy64 !== 1'b0 || en64 !== 1'b0) begin errors++;
        $display("FAIL idle_word got ready=%b busy=%b en=%b want 0 0 0", ready64, busy64, en64); end
    end
    word_valid = 1'b0;
  endtask

  task automatic test_load();
    int ns, da, fe, nrb, r1a, st; logic [63:0] s; logic [31:0] r0, r1; logic rd;
    use40 = 1'b0;
    run_load(32'hA5A50F0F, 32'h12345678, 0, -1, ns, da, fe, s, nrb, r0, r1, r1a, st, rd);
    checks++; if (ns !== 64) begin errors++; $display("FAIL load_shifts got %0d want 64", ns); end
    checks++; if (s !== 64'hA5A50F0F12345678) begin errors++; $display("FAIL load_stream got %h want a5a50f0f12345678", s); end
    checks++; if (fe !== 2) begin errors++; $display("FAIL load_first_en got %0d want 2", fe); end
    checks++; if (da !== 66) begin errors++; $display("FAIL load_done_at got %0d want 66", da); end
    checks++; if (st !== 0) begin errors++; $display("FAIL load_bubbles got %0d want 0", st); end
    checks++; if (rd !== 1'b0) begin errors++; $display("FAIL load_ready_in_done got %b want 0", rd); end
    checks++; if (nrb !== 2 || r0 !== 32'h0 || r1 !== 32'h0) begin errors++;
      $display("FAIL load_rb_empty got n=%0d %h %h want 2 0 0", nrb, r0, r1); end
    @(negedge clk);
    checks++; if (busy64 !== 1'b0) begin errors++; $display("FAIL load_idle_after got busy=%b want 0", busy64); end
  endtask

  task automatic test_readback();
    int ns, da, fe, nrb, r1a, st; logic [63:0] s; logic [31:0] r0, r1; logic rd;
    use40 = 1'b0;
    // A second start in the middle of the load must be ignored.
    run_load(32'hFFFFFFFF, 32'hFFFFFFFF, 0, 10, ns, da, fe, s, nrb, r0, r1, r1a, st, rd);
    checks++; if (nrb !== 2) begin errors++; $display("FAIL rb_count got %0d want 2", nrb); end
    checks++; if (r0 !== 32'hA5A50F0F) begin errors++; $display("FAIL rb_word0 got %h want a5a50f0f", r0); end
    checks++; if (r1 !== 32'h12345678) begin errors++; $display("FAIL rb_word1 got %h want 12345678", r1); end
    checks++; if (r1a !== 66) begin errors++; $display("FAIL rb_word1_at got %0d want 66", r1a); end
    checks++; if (da !== 66 || ns !== 64) begin errors++;
      $display("FAIL busy_start got done_at=%0d shifts=%0d want 66 64", da, ns); end
  endtask

  task automatic test_gap();
    int ns, da, fe, nrb, r1a, st; logic [63:0] s; logic [31:0] r0, r1; logic rd;
    use40 = 1'b0;
    run_load(32'hC3C33C3C, 32'h0F1E2D3C, 5, -1, ns, da, fe, s, nrb, r0, r1, r1a, st, rd);
    checks++; if (st !== 5) begin errors++; $display("FAIL gap_stalls got %0d want 5", st); end
    checks++; if (ns !== 64) begin errors++; $display("FAIL gap_shifts got %0d want 64", ns); end
    checks++; if (s !== 64'hC3C33C3C0F1E2D3C) begin errors++; $display("FAIL gap_stream got %h want c3c33c3c0f1e2d3c", s); end
    checks++; if (da !== 71) begin errors++; $display("FAIL gap_done_at got %0d want 71", da); end
    checks++; if (r0 !== 32'hFFFFFFFF || r1 !== 32'hFFFFFFFF) begin errors++;
      $display("FAIL gap_rb got %h %h want ffffffff ffffffff", r0, r1); end
  endtask

  task automatic test_reset_mid();
    int ns;
    bit seen;
    ns = 0; seen = 1'b0;
    @(negedge clk);
    start64 = 1'b1; word_in = 32'h55AA55AA; word_valid = 1'b1;
    for (int i = 0; i < 100 && ns < 20; i++) begin
      @(negedge clk);
      start64 = 1'b0;
      if (en64) ns++;
    end
    checks++; if (ns !== 20) begin errors++; $display("FAIL mid_reach got %0d want 20", ns); end
    rst_n = 1'b0;
    #1;
    checks++; if ({ready64, en64, d64, rbv64, done64, busy64} !== 6'b0 || rb64 !== 32'h0) begin errors++;
      $display("FAIL mid_reset_out got %b/%h want 0", {ready64, en64, d64, rbv64, done64, busy64}, rb64); end
    @(negedge clk);
    word_valid = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done64 || rbv64 || busy64 || en64) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_after got activity=%b want 0", seen); end
  endtask

  task automatic test_partial();
    int ns, da, fe, nrb, r1a, st; logic [63:0] s; logic [31:0] r0, r1; logic rd;
    use40 = 1'b1;
    run_load(32'hA5A50F0F, 32'h12345678, 0, -1, ns, da, fe, s, nrb, r0, r1, r1a, st, rd);
    checks++; if (ns !== 40) begin errors++; $display("FAIL p40_shifts got %0d want 40", ns); end
    checks++; if (s !== 64'h000000A5A50F0F12) begin errors++; $display("FAIL p40_stream got %h want a5a50f0f12", s); end
    checks++; if (da !== 42 || rd !== 1'b0) begin errors++;
      $display("FAIL p40_done got at=%0d ready=%b want 42 0", da, rd); end
    @(negedge clk);
    run_load(32'hFFFFFFFF, 32'hFFFFFFFF, 0, -1, ns, da, fe, s, nrb, r0, r1, r1a, st, rd);
    checks++; if (r0 !== 32'hA5A50F0F) begin errors++; $display("FAIL p40_rb0 got %h want a5a50f0f", r0); end
    checks++; if (r1 !== 32'h00000012 || r1a !== 42) begin errors++;
      $display("FAIL p40_rb1 got %h at %0d want 00000012 at 42", r1, r1a); end
    use40 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle_words();
    test_load();
    test_readback();
    test_gap();
    test_reset_mid();
    test_partial();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
